blake_round_sequencer: RTL

//  Drives the BLAKE-512 compression rounds from the read side. It holds the 16x64 working state v and steps

---
 rtl/blake_pkg.sv | 26 ++
 rtl/blake_operand_select.sv | 21 ++
 rtl/blake_round_sequencer.sv | 110 +++++++++++
 3 files changed

// File: rtl/blake_pkg.sv
// Shared BLAKE-512 sequencing definitions: word geometry, FSM encoding,
// packed-state word accessor and the per-step G operand index table.
package blake_pkg;
  localparam int W               = 64;
  localparam int NWORDS          = 16;
  localparam int STEPS_PER_ROUND = 8;
  localparam int VW              = W * NWORDS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  // Slot s holds {ia,ib,ic,id} for G-step s: four columns, then four diagonals.
  localparam logic [STEPS_PER_ROUND-1:0][15:0] OP_IDX = {
    16'h349E, 16'h278D, 16'h16BC, 16'h05AF,
    16'h37BF, 16'h26AE, 16'h159D, 16'h048C
  };

  // v0 lives in the most significant 64 bits.
  function automatic logic [W-1:0] word(input logic [VW-1:0] v, input logic [3:0] i);
    return v[VW-1-W*int'(i) -: W];
  endfunction
endpackage

// File: rtl/blake_operand_select.sv
// Combinational G operand mux: picks v[ia], v[ib], v[ic], v[id] for one step.
module blake_operand_select
  import blake_pkg::*;
(
  input  logic [VW-1:0] v_i,
  input  logic [2:0]    step_i,
  output logic [W-1:0]  a_o,
  output logic [W-1:0]  b_o,
  output logic [W-1:0]  c_o,
  output logic [W-1:0]  d_o
);
  logic [15:0] idx;

  always_comb begin
    idx = OP_IDX[step_i];
    a_o = word(v_i, idx[15:12]);
    b_o = word(v_i, idx[11:8]);
    c_o = word(v_i, idx[7:4]);
    d_o = word(v_i, idx[3:0]);
  end
endmodule

// File: rtl/blake_round_sequencer.sv
// Steps the BLAKE-512 working state through NUM_ROUNDS x 8 G-steps, handing
// operands to an external G core with a req/ack handshake.
module blake_round_sequencer
  import blake_pkg::*;
#(
  parameter int NUM_ROUNDS = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [VW-1:0] v_init,
  output logic          busy,
  output logic          done,
  output logic [VW-1:0] v_final,
  output logic [6:0]    counter_idx,
  output logic [3:0]    round_idx,
  output logic          g_req,
  output logic [W-1:0]  a_in,
  output logic [W-1:0]  b_in,
  output logic [W-1:0]  c_in,
  output logic [W-1:0]  d_in,
  input  logic          g_ack,
  output logic [VW-1:0] v_out,
  input  logic [VW-1:0] v_state_next,
  output seq_state_e    dbg_state_o
);
  localparam logic [6:0] LAST_IDX = 7'(NUM_ROUNDS * STEPS_PER_ROUND - 1);

  // Handshake: g_req is high only in ISSUE; a..d are valid from that cycle and
  // held until the g_ack that is sampled in WAIT. g_ack in any other state is ignored.
  seq_state_e    state_q, state_d;
  logic [VW-1:0] v_q, v_d;
  logic [6:0]    cnt_q, cnt_d;
  logic [W-1:0]  a_q, b_q, c_q, d_q;
  logic [W-1:0]  sel_a, sel_b, sel_c, sel_d;

  // Select from next-state values so operands are already valid while g_req is high.
  blake_operand_select u_sel (
    .v_i    (v_d),
    .step_i (cnt_d[2:0]),
    .a_o    (sel_a),
    .b_o    (sel_b),
    .c_o    (sel_c),
    .d_o    (sel_d)
  );

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          v_d     = v_init;
          cnt_d   = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (g_ack) begin
          v_d = v_state_next;
          if (cnt_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            cnt_d   = cnt_q + 7'd1;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      v_q     <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      cnt_q   <= cnt_d;
      if (state_d == ST_ISSUE) begin
        a_q <= sel_a;
        b_q <= sel_b;
        c_q <= sel_c;
        d_q <= sel_d;
      end
    end
  end

  assign busy        = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign done        = (state_q == ST_DONE);
  assign g_req       = (state_q == ST_ISSUE);
  assign v_final     = v_q;
  assign v_out       = v_q;
  assign counter_idx = cnt_q;
  assign round_idx   = cnt_q[6:3];
  assign a_in        = a_q;
  assign b_in        = b_q;
  assign c_in        = c_q;
  assign d_in        = d_q;
  assign dbg_state_o = state_q;
endmodule
